// File: rtl/ldpc_enc_serial_pkg.sv
// Shared definitions for the serial systematic LDPC encoder: default code
// dimensions, FSM encodings and the P_t row-slice helper.
package ldpc_enc_serial_pkg;

    localparam int LDPC_N   = 204;
    localparam int LDPC_K   = 102;
    localparam int LDPC_BPC = 6;

    typedef enum logic [1:0] {
        LDPC_ENC_IDLE = 2'd0,
        LDPC_ENC_ENC  = 2'd1,
        LDPC_ENC_DONE = 2'd2
    } ldpc_enc_state_e;

    // LSB of row k in a flattened P_t whose rows are pw bits wide
    function automatic int row_lsb(input int k, input int pw);
        return k * pw;
    endfunction

endpackage

// File: rtl/ldpc_enc_serial_step.sv
// One encoding step: XOR of the P_t rows selected by BPC message bits.
module ldpc_enc_serial_step #(
    parameter int PW  = 102,
    parameter int BPC = 6
) (
    input  logic [BPC-1:0]         bits_i,
    input  logic [BPC-1:0][PW-1:0] rows_i,
    output logic [PW-1:0]          par_o
);

    always_comb begin
        par_o = '0;
        for (int j = 0; j < BPC; j++) begin
            if (bits_i[j]) par_o = par_o ^ rows_i[j];
        end
    end

endmodule

// File: rtl/ldpc_enc_serial.sv
// Serial systematic LDPC encoder: parity = msg * P over GF(2), BPC bits per
// cycle, codeword {parity, msg} held in DONE until the sink takes it.
module ldpc_enc_serial
    import ldpc_enc_serial_pkg::*;
#(
    parameter int N   = LDPC_N,
    parameter int K   = LDPC_K,
    parameter int BPC = LDPC_BPC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [K*(N-K)-1:0]   P_t,
    input  logic [K-1:0]         in_msg,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N-1:0]         out_cw,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int PW    = N - K;
    localparam int STEPS = K / BPC;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IW    = (K > 1) ? $clog2(K) : 1;
    localparam int PIW   = $clog2(K * PW);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (K % BPC != 0) begin : g_bpc_chk
            $error("ldpc_enc_serial: K must be a multiple of BPC");
        end
    endgenerate

    ldpc_enc_state_e       state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [K-1:0]          msg_q, msg_d;
    logic                  vld_q, vld_d;

    logic [BPC-1:0]         step_bits;
    logic [BPC-1:0][PW-1:0] step_rows;
    logic [PW-1:0]          step_par;
    logic                   accept;

    // Row mux: step cnt covers message bits cnt*BPC .. cnt*BPC+BPC-1
    always_comb begin : row_mux
        logic [IW-1:0]  idx;
        logic [PIW-1:0] base;
        step_bits = '0;
        step_rows = '0;
        for (int j = 0; j < BPC; j++) begin
            idx          = IW'(cnt_q) * IW'(BPC) + IW'(j);
            base         = PIW'(idx) * PIW'(PW);
            step_bits[j] = msg_q[idx];
            step_rows[j] = P_t[base +: PW];
        end
    end

    ldpc_enc_serial_step #(.PW(PW), .BPC(BPC)) u_step (
        .bits_i (step_bits),
        .rows_i (step_rows),
        .par_o  (step_par)
    );

    assign in_ready = ~rst & ((state_q == LDPC_ENC_IDLE) |
                              ((state_q == LDPC_ENC_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        msg_d   = msg_q;
        vld_d   = vld_q;
        case (state_q)
            LDPC_ENC_IDLE: begin
                if (accept) begin
                    msg_d   = in_msg;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = LDPC_ENC_ENC;
                end
            end
            LDPC_ENC_ENC: begin
                acc_d = acc_q ^ step_par;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    vld_d   = 1'b1;
                    state_d = LDPC_ENC_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LDPC_ENC_DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = LDPC_ENC_IDLE;
                    // Hand over straight into the next message without a bubble
                    if (in_valid) begin
                        msg_d   = in_msg;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = LDPC_ENC_ENC;
                    end
                end
            end
            default: begin
                state_d = LDPC_ENC_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LDPC_ENC_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            msg_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            msg_q   <= msg_d;
            vld_q   <= vld_d;
        end
    end

    assign out_cw    = {acc_q, msg_q};
    assign out_valid = vld_q;
    assign busy      = (state_q == LDPC_ENC_ENC);

endmodule

// File: tb/tb_ldpc_enc_serial.sv
// Directed bench for ldpc_enc_serial: latency, unit vectors, random vs. a
// row-by-row GF(2) model, backpressure, back-to-back and mid-encode reset.
module tb_ldpc_enc_serial;
    import ldpc_enc_serial_pkg::*;

    localparam int N   = 204;
    localparam int K   = 102;
    localparam int BPC = 6;
    localparam int PW  = N - K;
    localparam int LAT = K / BPC;

    logic               clk;
    logic               rst;
    logic [K*PW-1:0]    p_t;
    logic [K-1:0]       in_msg;
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       out_cw;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    ldpc_enc_serial #(.N(N), .K(K), .BPC(BPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .P_t       (p_t),
        .in_msg    (in_msg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_cw    (out_cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [K-1:0] m);
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < K; k++)
            if (m[k]) p = p ^ p_t[row_lsb(k, PW) +: PW];
        return p;
    endfunction

    function automatic logic [K-1:0] rnd_msg();
        logic [K-1:0] m;
        for (int i = 0; i < K; i++) m[i] = 1'($urandom_range(0, 1));
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic encode(input logic [K-1:0] m, output logic [N-1:0] cw, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        if (!in_ready) chk("accept_timeout", N'(in_ready), N'(1));
        in_msg   = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        cw = out_cw;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [K-1:0] m, one;
        logic [N-1:0] cw, cw0;
        logic [K-1:0] msgs [20];
        int lat, w, sent, got, last_acc, cyc;
        logic acc, hs, seen;
        logic [N-1:0] cwcap;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_msg = '0;
        for (int i = 0; i < K*PW; i++) p_t[i] = 1'($urandom_range(0, 1));
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", N'(out_valid), N'(0));
        chk("rst_busy",      N'(busy),      N'(0));
        chk("rst_in_ready",  N'(in_ready),  N'(1));
        chk("rst_out_cw",    out_cw,        '0);

        // all-zero message
        encode('0, cw, lat);
        chk("zero_lat", N'(lat), N'(LAT));
        chk("zero_cw",  cw, '0);

        // unit vectors select single rows
        one = '0; one[5] = 1'b1;
        encode(one, cw, lat);
        chk("bit5_lat", N'(lat), N'(LAT));
        chk("bit5_cw",  cw, {p_t[5*PW +: PW], one});
        one = '0; one[101] = 1'b1;
        encode(one, cw, lat);
        chk("bit101_cw", cw, {p_t[101*PW +: PW], one});

        for (int t = 0; t < 500; t++) begin
            m = rnd_msg();
            encode(m, cw, lat);
            chk("rand_cw", cw, {model(m), m});
        end

        // backpressure
        m = rnd_msg();
        in_msg = m; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin tick(); w++; end
        cw0 = out_cw;
        chk("bp_cw0", cw0, {model(m), m});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_cw_stable", out_cw, cw0);
            chk("bp_in_ready",  N'(in_ready),  N'(0));
            chk("bp_busy",      N'(busy),      N'(0));
            chk("bp_out_valid", N'(out_valid), N'(1));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", N'(in_ready), N'(1));
        tick();
        out_ready = 1'b0;
        chk("bp_drop_valid", N'(out_valid), N'(0));
        chk("bp_idle_busy",  N'(busy),      N'(0));

        // back-to-back
        for (int i = 0; i < 20; i++) msgs[i] = rnd_msg();
        sent = 0; got = 0; last_acc = -1; cyc = 0;
        in_msg = msgs[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (got < 20 && cyc < 20*(LAT+1) + 100) begin
            acc   = in_valid & in_ready;
            hs    = out_valid & out_ready;
            cwcap = out_cw;
            tick();
            cyc++;
            if (acc) begin
                if (sent > 0) chk("b2b_gap", N'(cyc - last_acc), N'(LAT + 1));
                last_acc = cyc;
                sent++;
                if (sent < 20) in_msg = msgs[sent];
                else in_valid = 1'b0;
            end
            if (hs) begin
                if (got < sent) chk("b2b_cw", cwcap, {model(msgs[got]), msgs[got]});
                else chk("b2b_extra_cw", N'(got), N'(sent - 1));
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_count", N'(got), N'(20));
        chk("b2b_sent",  N'(sent), N'(20));

        // reset mid-encode
        m = rnd_msg();
        in_msg = m; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        #1;
        chk("mrst_in_ready",  N'(in_ready),  N'(0));
        chk("mrst_out_valid", N'(out_valid), N'(0));
        chk("mrst_busy",      N'(busy),      N'(0));
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_after_in_ready", N'(in_ready), N'(1));
        chk("mrst_after_busy",     N'(busy),     N'(0));
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen = seen | out_valid;
        end
        chk("mrst_no_output", N'(seen), N'(0));
        m = rnd_msg();
        encode(m, cw, lat);
        chk("mrst_next_lat", N'(lat), N'(LAT));
        chk("mrst_next_cw",  cw, {model(m), m});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
